sequential_left_shift: RTL and testbench

SEQUENTIAL_LEFT_SHIFT -- requirements
Module: sequential_left_shift

---
 rtl/sequential_left_shift.sv | 61 ++++++
 tb/tb_sequential_left_shift.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sequential_left_shift.sv
// sequential_left_shift: 32-bit logical left shift performed two bits per clock with overflow detection
module sequential_left_shift (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [4:0]  shamt,
    output logic [31:0] out,
    output logic        done,
    output logic        busy,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] out_q, out_d;
    logic [4:0]  rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        two_step;
    // state and datapath registers, cleared asynchronously so an abort leaves no trace
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end
    // next-state logic: load on accepted start, shift by two (or one for the odd remainder), flag lost ones
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        two_step = rem_q >= 5'd2;
        case (state_q)
            IDLE: if (start) begin
                out_d   = in;
                rem_d   = shamt;
                ovf_d   = 1'b0;
                state_d = (shamt == 5'd0) ? DONE : SHIFT;
            end
            SHIFT: begin
                out_d   = two_step ? {out_q[29:0], 2'b00} : {out_q[30:0], 1'b0};
                rem_d   = two_step ? rem_q - 5'd2 : 5'd0;
                ovf_d   = ovf_q | out_q[31] | (two_step & out_q[30]);
                state_d = (rem_d == 5'd0) ? DONE : SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign out  = out_q;
    assign ovf  = ovf_q;
    assign done = state_q == DONE;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_sequential_left_shift.sv
// tb_sequential_left_shift: random and directed checks of the sequential shifter against a cycle-count model
module tb_sequential_left_shift;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] in_s;
    logic [4:0]  shamt_s;
    logic [31:0] out;
    logic        done, busy, ovf;
    int          vectors = 0;
    int          fails = 0;
    int          dcount = 0;
    int          cnt;
    logic [31:0] exp_out;
    logic        exp_ovf;

    sequential_left_shift dut (
        .clock(clock), .reset_n(reset_n), .start(start), .in(in_s), .shamt(shamt_s),
        .out(out), .done(done), .busy(busy), .ovf(ovf)
    );

    always #5 clock = ~clock;

    function automatic logic [32:0] ref_shift(input logic [31:0] a, input logic [4:0] s);
        logic [63:0] w;
        w = {32'b0, a} << s;
        return {w[63:32] != 32'b0, w[31:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: cnt = cycles remaining until idle; busy while nonzero, done on the last one
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= 0;
            exp_out <= '0;
            exp_ovf <= 1'b0;
        end else if (cnt == 0 && start) begin
            cnt     <= 1 + (int'(shamt_s) + 1) / 2;
            exp_out <= ref_shift(in_s, shamt_s) >> 0;
            exp_ovf <= ref_shift(in_s, shamt_s) >> 32;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    initial forever begin
        @(negedge clock);
        if (done === 1'b1) dcount++;
        check("model_done", {31'b0, done}, {31'b0, cnt == 1});
        check("model_busy", {31'b0, busy}, {31'b0, cnt != 0});
        if (cnt <= 1) begin
            check("model_out", out, exp_out);
            check("model_ovf", {31'b0, ovf}, {31'b0, exp_ovf});
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [4:0] s, output int lat, output int busyc);
        @(posedge clock);
        #1 start = 1'b1; in_s = a; shamt_s = s;
        @(posedge clock);
        #1 start = 1'b0; in_s = $urandom; shamt_s = 5'($urandom);
        lat = 0;
        busyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            lat++;
            if (busy) busyc++;
            if (done) break;
        end
        if (!done) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, busyc, d0;
        reset_n = 1'b0; start = 1'b0; in_s = '0; shamt_s = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out", out, 32'h0);
        check("rst_flags", {29'b0, done, busy, ovf}, 32'h0);
        reset_n = 1'b1;
        run_op(32'h0000_0001, 5'd5, lat, busyc);
        check("odd_out", out, 32'h0000_0020);
        check("odd_ovf", {31'b0, ovf}, 32'h0);
        check("odd_lat", lat, 4);
        check("odd_busy", busyc, 4);
        run_op(32'hDEAD_BEEF, 5'd0, lat, busyc);
        check("zero_out", out, 32'hDEAD_BEEF);
        check("zero_ovf", {31'b0, ovf}, 32'h0);
        check("zero_lat", lat, 1);
        run_op(32'hFFFF_FFFF, 5'd31, lat, busyc);
        check("max_out", out, 32'h8000_0000);
        check("max_ovf", {31'b0, ovf}, 32'h1);
        check("max_lat", lat, 17);
        repeat (2) @(negedge clock);
        check("hold_out", out, 32'h8000_0000);
        check("hold_ovf", {31'b0, ovf}, 32'h1);
        d0 = dcount;
        @(posedge clock);
        #1 start = 1'b1; in_s = 32'h0000_0003; shamt_s = 5'd4;
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        #1 start = 1'b1; in_s = 32'hFFFF_FFFF; shamt_s = 5'd7;
        @(posedge clock);
        #1;
        check("ign_in_done", {31'b0, done}, 32'h1);
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        check("ign_out", out, 32'h0000_0030);
        check("ign_dones", dcount - d0, 1);
        @(posedge clock);
        #1 start = 1'b1; in_s = 32'h1234_5678; shamt_s = 5'd8;
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        d0 = dcount;
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("abort_out", out, 32'h0);
        check("abort_flags", {29'b0, done, busy, ovf}, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check("abort_dones", dcount - d0, 0);
        run_op(32'h0000_0001, 5'd2, lat, busyc);
        check("post_rst_out", out, 32'h0000_0004);
        check("post_rst_lat", lat, 2);
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a;
            logic [4:0]  s;
            logic [32:0] r;
            a = $urandom;
            s = 5'($urandom);
            if (i % 4 == 0) a = a >> $urandom_range(31, 0);
            r = ref_shift(a, s);
            run_op(a, s, lat, busyc);
            check("rnd_out", out, r[31:0]);
            check("rnd_ovf", {31'b0, ovf}, {31'b0, r[32]});
            check("rnd_lat", lat, 1 + (int'(s) + 1) / 2);
            repeat ($urandom_range(1, 0)) @(posedge clock);
        end
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
